dmem_responder: RTL

Multi-cycle data-memory responder that sits on the MEM-stage side of the pipelined core and answers the core's load/store requests (MemRead/MemWrite, byte address, store data). It holds a word-organised RAM, inserts a configurable number of wait states, and drives a Stall signal back to the pipeline so the core freezes until the access completes. Bad requests are flagged with Error instead of touching the array.

---
 rtl/dmem_responder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder
// Multi-cycle data-memory responder for the MEM stage of the pipelined core.
// It captures a load/store request, waits a fixed number of cycles and then
// returns Ready for one cycle. Error is raised with Ready for an illegal
// request, and an illegal request never touches the array. While an access is
// in progress, Stall holds the pipeline.
//
// Ports
//   Clk        rising-edge clock
//   Reset      asynchronous, active-high; clears everything except the array
//   MemRead    load request, held stable by the core while Stall=1
//   MemWrite   store request, held stable by the core while Stall=1
//   Addr       byte address; must be word aligned and inside DEPTH words
//   WData      store data
//   RData      registered load data; holds its value between loads
//   Ready      registered; pulses for one cycle when an access completes
//   Error      registered; pulses with Ready if the request was illegal
//   Stall      combinational; the core must not advance while it is high
module dmem_responder #(
   parameter int DEPTH   = 256,
   parameter int LATENCY = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] Addr,
   input  logic [31:0] WData,
   output logic [31:0] RData,
   output logic        Ready,
   output logic        Error,
   output logic        Stall
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [31:0]     rdata_q, rdata_d;
   logic            ready_q, ready_d;
   logic            error_q, error_d;
   // Latched request
   logic            rd_q, rd_d;
   logic            wr_q, wr_d;
   logic            bad_q, bad_d;
   logic [AW-1:0]   widx_q, widx_d;
   logic [31:0]     wdata_q, wdata_d;

   logic [31:0]     mem_q [DEPTH];
   logic            req;
   logic            req_bad;
   logic            resp_entry;
   logic            mem_we;

   assign req     = MemRead | MemWrite;
   assign req_bad = (Addr[1:0] != 2'b00)
                  | ({2'b00, Addr[31:2]} >= 32'(DEPTH))
                  | (MemRead & MemWrite);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      ready_d    = 1'b0;
      error_d    = 1'b0;
      rd_d       = rd_q;
      wr_d       = wr_q;
      bad_d      = bad_q;
      widx_d     = widx_q;
      wdata_d    = wdata_q;
      Stall      = 1'b0;
      resp_entry = 1'b0;
      mem_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req) begin
               Stall   = 1'b1;
               rd_d    = MemRead;
               wr_d    = MemWrite;
               bad_d   = req_bad;
               widx_d  = Addr[AW+1:2];
               wdata_d = WData;
               cnt_d   = CNT_INIT;
               if (LATENCY == 0) begin
                  state_d    = S_RESP;
                  resp_entry = 1'b1;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            Stall = 1'b1;
            if (cnt_q == 4'd0) begin
               state_d    = S_RESP;
               resp_entry = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // The store commits on the edge that leaves RESP, so a read
            // captured in the next IDLE cycle already sees the new data.
            state_d = S_IDLE;
            mem_we  = wr_q & ~bad_q;
         end
         default: state_d = S_IDLE;
      endcase

      // The _d request fields hold the live inputs on a zero-latency entry
      // from IDLE and the latched copy on an entry from WAIT.
      if (resp_entry) begin
         ready_d = 1'b1;
         error_d = bad_d;
         if (rd_d) rdata_d = bad_d ? 32'd0 : mem_q[widx_d];
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         ready_q <= 1'b0;
         error_q <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         bad_q   <= 1'b0;
         widx_q  <= '0;
         wdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         error_q <= error_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         bad_q   <= bad_d;
         widx_q  <= widx_d;
         wdata_q <= wdata_d;
      end
   end

   // The array is not reset. A reset that lands on the commit edge
   // discards the pending store.
   always_ff @(posedge Clk) begin
      if (mem_we && !Reset) mem_q[widx_q] <= wdata_q;
   end

   assign RData = rdata_q;
   assign Ready = ready_q;
   assign Error = error_q;

endmodule
